// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard logic: scoreboard entry
// layout, the regfile forwarding code and position/mask helpers.
package pipe_pkg;

  localparam int unsigned WA_W   = 16;
  localparam int unsigned FWD_RF = 0;

  // One in-flight register write; wa is zero-extended from the datapath width.
  typedef struct packed {
    logic            v;
    logic [WA_W-1:0] wa;
    logic            load;
  } sb_entry_t;

  // Scoreboard array index 0 holds pipeline position 1 (EX).
  function automatic int unsigned pos_of(input int unsigned idx);
    return idx + 1;
  endfunction

  // Mask with bits [n:0] set.
  function automatic logic [31:0] low_ones(input int unsigned n);
    return (32'(1) << (n + 1)) - 32'(1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand scoreboard search: reports the youngest in-flight writer of src.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned PW    = 2
) (
  input  sb_entry_t        sb [DEPTH],
  input  logic [AW-1:0]    src,
  input  logic             use_src,
  input  logic             id_valid,
  output logic             hit,
  output logic [PW-1:0]    pos,
  output logic             load
);

  // Scan from EX outward; the first hit is the youngest producer.
  always_comb begin
    hit  = 1'b0;
    pos  = '0;
    load = 1'b0;
    if (id_valid && use_src && (src != '0)) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (!hit && sb[i].v && (sb[i].wa == WA_W'(src))) begin
          hit  = 1'b1;
          pos  = PW'(pos_of(i));
          load = sb[i].load;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Interlock and forwarding controller: tracks in-flight writes and drives
// load-use stalls, branch flushes and EX operand forwarding selects.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned AW       = 5,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned BR_STAGE = 3,
  parameter int unsigned CW       = 32,
  parameter int unsigned SW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_we,
  input  logic [AW-1:0]    id_wa,
  input  logic             id_load,
  input  logic             br_taken,
  input  logic             ext_stall,
  output logic             hold_f,
  output logic [DEPTH:0]   kill,
  output logic [SW-1:0]    fwd_a,
  output logic [SW-1:0]    fwd_b,
  output logic [CW-1:0]    stall_cnt,
  output logic [CW-1:0]    flush_cnt
);

  localparam int unsigned PW       = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LL     = PW'(LOAD_LAT);
  localparam logic [PW-1:0] LAST   = PW'(DEPTH);
  localparam logic [DEPTH:0] BR_MASK = (DEPTH + 1)'(low_ones(BR_STAGE));
  localparam logic [CW-1:0] CNT_MAX = '1;

  sb_entry_t       sb [DEPTH];
  logic            hit_a, hit_b, ld_a, ld_b;
  logic [PW-1:0]   pos_a, pos_b;
  logic            flush_c, stall_c, bubble_c;
  logic [SW-1:0]   sel_a_c, sel_b_c;

  hazard_match #(.DEPTH(DEPTH), .AW(AW), .PW(PW)) u_match_a (
    .sb       (sb),
    .src      (id_rs),
    .use_src  (id_use_rs),
    .id_valid (id_valid),
    .hit      (hit_a),
    .pos      (pos_a),
    .load     (ld_a)
  );

  hazard_match #(.DEPTH(DEPTH), .AW(AW), .PW(PW)) u_match_b (
    .sb       (sb),
    .src      (id_rt),
    .use_src  (id_use_rt),
    .id_valid (id_valid),
    .hit      (hit_b),
    .pos      (pos_b),
    .load     (ld_b)
  );

  // Control decode: ext_stall freezes everything, a flush overrides a stall.
  always_comb begin
    flush_c  = br_taken & ~ext_stall;
    stall_c  = ~ext_stall & ~flush_c &
               ((hit_a & ld_a & (pos_a < LL)) | (hit_b & ld_b & (pos_b < LL)));
    bubble_c = flush_c | stall_c;
    hold_f   = ext_stall | stall_c;
    kill     = '0;
    if (flush_c) begin
      kill = BR_MASK;
    end else if (stall_c) begin
      kill[1] = 1'b1;
    end
    sel_a_c = SW'(FWD_RF);
    sel_b_c = SW'(FWD_RF);
    if (!bubble_c && hit_a && (pos_a < LAST)) sel_a_c = SW'(pos_a);
    if (!bubble_c && hit_b && (pos_b < LAST)) sel_b_c = SW'(pos_b);
  end

  // Scoreboard shift; flushed positions come up empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) sb[i] <= '0;
    end else if (!ext_stall) begin
      sb[0] <= sb_entry_t'{
        v:    id_valid & id_we & (id_wa != '0) & ~kill[1],
        wa:   WA_W'(id_wa),
        load: id_load
      };
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sb[i] <= (flush_c && (i < BR_STAGE)) ? sb_entry_t'('0) : sb[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a     <= '0;
      fwd_b     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!ext_stall) begin
      fwd_a <= sel_a_c;
      fwd_b <= sel_b_c;
      if (stall_c && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CW'(1);
      if (flush_c && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CW'(1);
    end
  end

endmodule
